// File: rtl/biquad_cascade_pkg.sv
// Shared types and fixed-point helpers for the time-multiplexed biquad cascade.
// Helpers work on a wide signed intermediate so callers pick widths at the call site.
package biquad_cascade_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_WB   = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  localparam int B0          = 0;
  localparam int B1          = 1;
  localparam int B2          = 2;
  localparam int A1          = 3;
  localparam int A2          = 4;
  localparam int BYPASS_WORD = 5;
  localparam int NCOEF       = 5;
  localparam int CFG_WORD_W  = 32;
  localparam int MATH_W      = 128;

  function automatic logic signed [MATH_W-1:0] pow2(input int n);
    logic signed [MATH_W-1:0] r;
    r = MATH_W'(1);
    return r <<< n;
  endfunction

  // Round half up, then drop frac bits (frac must be >= 1).
  function automatic logic signed [MATH_W-1:0] round_shift(
    input logic signed [MATH_W-1:0] v, input int frac);
    logic signed [MATH_W-1:0] t;
    t = v + pow2(frac - 1);
    return t >>> frac;
  endfunction

  function automatic logic sat_needed(input logic signed [MATH_W-1:0] v, input int w);
    logic signed [MATH_W-1:0] hi;
    logic signed [MATH_W-1:0] lo;
    hi = pow2(w - 1) - 1;
    lo = -pow2(w - 1);
    return (v > hi) || (v < lo);
  endfunction

  function automatic logic signed [MATH_W-1:0] saturate(
    input logic signed [MATH_W-1:0] v, input int w);
    logic signed [MATH_W-1:0] hi;
    logic signed [MATH_W-1:0] lo;
    hi = pow2(w - 1) - 1;
    lo = -pow2(w - 1);
    if (v > hi) return hi;
    else if (v < lo) return lo;
    else return v;
  endfunction

endpackage

// File: rtl/biquad_tdm_mac.sv
// Registered signed multiplier feeding an accumulator. The running sum is also
// presented combinationally so the product issued last can be consumed one cycle later.
module biquad_tdm_mac #(
  parameter int DATA_W = 32,
  parameter int COEF_W = 32,
  parameter int ACC_W  = 68
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic              valid,
  input  logic              clear,
  input  logic              negate,
  input  logic [COEF_W-1:0] coef,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  acc
);

  localparam int PROD_W = DATA_W + COEF_W;

  logic signed [PROD_W-1:0] prod;
  logic signed [PROD_W-1:0] prod_q;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [ACC_W-1:0]  acc_sum;
  logic                     v_q;
  logic                     clr_q;

  assign prod = $signed({{DATA_W{coef[COEF_W-1]}}, coef}) *
                $signed({{COEF_W{data[DATA_W-1]}}, data});

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      prod_q <= '0;
      v_q    <= 1'b0;
      clr_q  <= 1'b0;
      acc_q  <= '0;
    end else begin
      prod_q <= negate ? -prod : prod;
      v_q    <= valid;
      clr_q  <= clear;
      acc_q  <= acc_sum;
    end
  end

  assign prod_ext = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};

  // The clear flag travels with the first product of a section.
  always_comb begin
    acc_sum = acc_q;
    if (v_q) acc_sum = clr_q ? prod_ext : acc_q + prod_ext;
  end

  assign acc = acc_sum;

endmodule

// File: rtl/axis_biquad_cascade_tdm.sv
// NSEC cascaded DF1 biquads sharing one MAC; each sample walks every section in turn.
// Per-section coefficients, bypass and state live here; the MAC is a sub-module.
module axis_biquad_cascade_tdm
  import biquad_cascade_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DATA_FRAC   = 31,
  parameter int COEF_W      = 32,
  parameter int COEF_FRAC   = 30,
  parameter int NSEC        = 4,
  parameter int GUARD       = 4,
  parameter int CONFIG_ADDR = 999
) (
  input  logic              aclk,
  input  logic              resetn,
  input  logic [31:0]       config_addr,
  input  logic [511:0]      config_data,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              overflow,
  output logic              busy
);

  localparam int ACC_W = DATA_W + COEF_W + GUARD;
  localparam int SEC_W = (NSEC > 1) ? $clog2(NSEC) : 1;
  localparam logic [COEF_W-1:0] COEF_ONE = COEF_W'(1) << COEF_FRAC;
  // Output scaling equals input scaling, so the sample Q format never enters the math.
  localparam int unused_data_frac = DATA_FRAC;

  state_t state, state_nxt;

  logic [SEC_W-1:0]         sec;
  logic [SEC_W-1:0]         sec_inc;
  logic [2:0]               step;
  logic signed [DATA_W-1:0] x_cur;

  logic signed [COEF_W-1:0] coef_q [NSEC][NCOEF];
  logic                     bypass_q [NSEC];
  logic signed [DATA_W-1:0] x1_q [NSEC];
  logic signed [DATA_W-1:0] x2_q [NSEC];
  logic signed [DATA_W-1:0] y1_q [NSEC];
  logic signed [DATA_W-1:0] y2_q [NSEC];

  logic [NSEC-1:0]          cfg_sel;
  logic                     cfg_hit;
  logic                     in_hs;
  logic                     last_sec;

  logic                     mac_valid;
  logic                     mac_clear;
  logic                     mac_neg;
  logic signed [COEF_W-1:0] mac_coef;
  logic signed [DATA_W-1:0] mac_data;
  logic [ACC_W-1:0]         acc_sum;

  logic signed [MATH_W-1:0] acc_ext;
  logic signed [MATH_W-1:0] rounded;
  logic                     sat_hit;
  logic signed [DATA_W-1:0] y_mac;
  logic signed [DATA_W-1:0] y_wb;
  logic                     unused_cfg;

  assign unused_cfg = ^config_data[511:CFG_WORD_W*BYPASS_WORD+1];

  always_comb begin
    cfg_sel = '0;
    for (int k = 0; k < NSEC; k++)
      cfg_sel[k] = (config_addr == 32'(CONFIG_ADDR + k));
  end
  assign cfg_hit = |cfg_sel;

  // AXIS: a beat transfers on a rising aclk edge where tvalid and tready are both
  // high. Output data is held stable while tvalid waits; a config write to a live
  // section withdraws tvalid because the sample it carried is discarded.
  assign s_axis_tready = resetn && (state == ST_IDLE) && !cfg_hit;
  assign m_axis_tvalid = (state == ST_OUT) && !cfg_hit;
  assign busy          = (state != ST_IDLE);
  assign in_hs         = s_axis_tvalid && s_axis_tready;
  assign last_sec      = (sec == SEC_W'(NSEC - 1));
  assign sec_inc       = sec + 1'b1;

  always_comb begin
    mac_coef = coef_q[sec][B0];
    mac_data = x_cur;
    mac_neg  = 1'b0;
    case (step)
      3'd1: begin mac_coef = coef_q[sec][B1]; mac_data = x1_q[sec]; end
      3'd2: begin mac_coef = coef_q[sec][B2]; mac_data = x2_q[sec]; end
      3'd3: begin mac_coef = coef_q[sec][A1]; mac_data = y1_q[sec]; mac_neg = 1'b1; end
      3'd4: begin mac_coef = coef_q[sec][A2]; mac_data = y2_q[sec]; mac_neg = 1'b1; end
      default: ;
    endcase
  end

  assign mac_valid = (state == ST_MAC) && !cfg_hit;
  assign mac_clear = (step == 3'd0);

  biquad_tdm_mac #(
    .DATA_W (DATA_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .aclk   (aclk),
    .resetn (resetn),
    .valid  (mac_valid),
    .clear  (mac_clear),
    .negate (mac_neg),
    .coef   (mac_coef),
    .data   (mac_data),
    .acc    (acc_sum)
  );

  assign acc_ext = {{(MATH_W-ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
  assign rounded = round_shift(acc_ext, COEF_FRAC);
  assign sat_hit = sat_needed(rounded, DATA_W);
  assign y_mac   = DATA_W'(saturate(rounded, DATA_W));
  assign y_wb    = bypass_q[sec] ? x_cur : y_mac;

  always_ff @(posedge aclk) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (in_hs) state_nxt = bypass_q[0] ? ST_WB : ST_MAC;
      ST_MAC:  if (step == 3'(NCOEF - 1)) state_nxt = ST_WB;
      ST_WB: begin
        if (last_sec) state_nxt = ST_OUT;
        else          state_nxt = bypass_q[sec_inc] ? ST_WB : ST_MAC;
      end
      ST_OUT:  if (m_axis_tready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (cfg_hit) state_nxt = ST_IDLE;
  end

  always_ff @(posedge aclk) begin
    if (!resetn) begin
      sec          <= '0;
      step         <= '0;
      x_cur        <= '0;
      m_axis_tdata <= '0;
      overflow     <= 1'b0;
      for (int k = 0; k < NSEC; k++) begin
        coef_q[k][B0] <= COEF_ONE;
        coef_q[k][B1] <= '0;
        coef_q[k][B2] <= '0;
        coef_q[k][A1] <= '0;
        coef_q[k][A2] <= '0;
        bypass_q[k]   <= 1'b0;
        x1_q[k]       <= '0;
        x2_q[k]       <= '0;
        y1_q[k]       <= '0;
        y2_q[k]       <= '0;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            x_cur <= s_axis_tdata;
            sec   <= '0;
            step  <= '0;
          end
        end
        ST_MAC: step <= (step == 3'(NCOEF - 1)) ? 3'd0 : step + 3'd1;
        ST_WB: begin
          if (!cfg_hit) begin
            x_cur <= y_wb;
            // Bypassed sections keep their history at zero.
            if (!bypass_q[sec]) begin
              x2_q[sec] <= x1_q[sec];
              x1_q[sec] <= x_cur;
              y2_q[sec] <= y1_q[sec];
              y1_q[sec] <= y_mac;
              if (sat_hit) overflow <= 1'b1;
            end
            if (last_sec) m_axis_tdata <= y_wb;
            else          sec <= sec_inc;
          end
        end
        default: ;
      endcase
      if (cfg_hit) begin
        overflow <= 1'b0;
        step     <= '0;
        for (int k = 0; k < NSEC; k++) begin
          if (cfg_sel[k]) begin
            for (int i = 0; i < NCOEF; i++)
              coef_q[k][i] <= config_data[CFG_WORD_W*i +: COEF_W];
            bypass_q[k] <= config_data[CFG_WORD_W*BYPASS_WORD];
            x1_q[k]     <= '0;
            x2_q[k]     <= '0;
            y1_q[k]     <= '0;
            y2_q[k]     <= '0;
          end
        end
      end
    end
  end

endmodule
